// File: rtl/cpu_cycle_seq.sv
// Machine-cycle sequencer for the MCS8 core: runs one T1/T2/(WAIT)/T3/T4 bus cycle per START_I
// and drives the cpu_stack read/strobe controls. Optional WAIT timeout: CPU_SEQ_WAIT_TIMEOUT_EN.
module cpu_cycle_seq #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic       CLK2_I,
  input  logic       nRST_I,
  input  logic       START_I,
  input  logic [1:0] CYC_I,
  input  logic       INCR_REQ_I,
  input  logic       PUSH_REQ_I,
  input  logic       POP_REQ_I,
  input  logic       READY_I,
  input  logic [7:0] STK_DAT_I,
  input  logic [7:0] WDAT_I,
  input  logic [7:0] BUS_I,
  output logic [7:0] BUS_O,
  output logic       BUS_OE_O,
  output logic       RD_O,
  output logic       HA_O,
  output logic       INCR_O,
  output logic       PUSH_O,
  output logic       POP_O,
  output logic [7:0] RD_DAT_O,
  output logic [2:0] STATE_O,
  output logic       SYNC_O,
  output logic       BUSY_O,
  output logic       DONE_O,
  output logic       TOUT_O
);

  // State codes double as the STATE_O pin encoding (S2..S0)
  localparam logic [2:0] ST_T1   = 3'b010;
  localparam logic [2:0] ST_T2   = 3'b100;
  localparam logic [2:0] ST_WAIT = 3'b000;
  localparam logic [2:0] ST_T3   = 3'b001;
  localparam logic [2:0] ST_T4   = 3'b111;
  localparam logic [2:0] ST_IDLE = 3'b011;

  logic [2:0] state_r;
  logic [2:0] state_n;
  logic       phase_r;
  logic       phase_n;
  logic [1:0] cyc_r;
  logic       incr_r;
  logic       push_r;
  logic       pop_r;
  logic [7:0] wdat_r;
  logic [7:0] rd_dat_r;
  logic       accept_s;
  logic       wait_expire_s;

  // A new cycle may start from IDLE or chain from the last clock of T4
  assign accept_s = START_I && ((state_r == ST_IDLE) || ((state_r == ST_T4) && phase_r));

`ifdef CPU_SEQ_WAIT_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);
  logic [7:0] wait_cnt_r;
  logic       tout_r;

  assign wait_expire_s = (state_r == ST_WAIT) && phase_r && !READY_I && (wait_cnt_r == WAIT_LAST);

  // Count completed WAIT T-states; restarted on each exit from T2
  always_ff @(posedge CLK2_I) begin
    if (!nRST_I) begin
      wait_cnt_r <= 8'd0;
    end else if ((state_r == ST_T2) && phase_r) begin
      wait_cnt_r <= 8'd0;
    end else if ((state_r == ST_WAIT) && phase_r) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Sticky timeout flag, cleared when the next cycle is accepted
  always_ff @(posedge CLK2_I) begin
    if (!nRST_I) begin
      tout_r <= 1'b0;
    end else if (accept_s) begin
      tout_r <= 1'b0;
    end else if (wait_expire_s) begin
      tout_r <= 1'b1;
    end else begin
      tout_r <= tout_r;
    end
  end

  assign TOUT_O = tout_r;
`else
  assign wait_expire_s = 1'b0;
  assign TOUT_O        = 1'b0;
`endif

  // Next T-state and phase; every T-state is phase A then phase B
  always_comb begin
    state_n = state_r;
    phase_n = phase_r;
    case (state_r)
      ST_IDLE: begin
        phase_n = 1'b0;
        if (START_I) begin
          state_n = ST_T1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_T1, ST_T3: begin
        if (phase_r) begin
          state_n = (state_r == ST_T1) ? ST_T2 : ST_T4;
          phase_n = 1'b0;
        end else begin
          phase_n = 1'b1;
        end
      end
      ST_T2, ST_WAIT: begin
        if (phase_r) begin
          state_n = (READY_I || wait_expire_s) ? ST_T3 : ST_WAIT;
          phase_n = 1'b0;
        end else begin
          phase_n = 1'b1;
        end
      end
      ST_T4: begin
        if (phase_r) begin
          state_n = START_I ? ST_T1 : ST_IDLE;
          phase_n = 1'b0;
        end else begin
          phase_n = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        phase_n = 1'b0;
      end
    endcase
  end

  // Sequencer state, latched cycle parameters and T3 read capture
  always_ff @(posedge CLK2_I) begin
    if (!nRST_I) begin
      state_r  <= ST_IDLE;
      phase_r  <= 1'b0;
      cyc_r    <= 2'b00;
      incr_r   <= 1'b0;
      push_r   <= 1'b0;
      pop_r    <= 1'b0;
      wdat_r   <= 8'h00;
      rd_dat_r <= 8'h00;
    end else begin
      state_r <= state_n;
      phase_r <= phase_n;
      if (accept_s) begin
        cyc_r  <= CYC_I;
        incr_r <= INCR_REQ_I;
        push_r <= PUSH_REQ_I;
        pop_r  <= POP_REQ_I;
        wdat_r <= WDAT_I;
      end else begin
        cyc_r  <= cyc_r;
        incr_r <= incr_r;
        push_r <= push_r;
        pop_r  <= pop_r;
        wdat_r <= wdat_r;
      end
      if ((state_r == ST_T3) && phase_r && (cyc_r != 2'b11)) begin
        rd_dat_r <= BUS_I;
      end else begin
        rd_dat_r <= rd_dat_r;
      end
    end
  end

  // Output decode from the registered state; PUSH wins over POP in T4 phase B
  always_comb begin
    BUS_O    = 8'h00;
    BUS_OE_O = 1'b0;
    RD_O     = 1'b0;
    HA_O     = 1'b0;
    INCR_O   = 1'b0;
    PUSH_O   = 1'b0;
    POP_O    = 1'b0;
    case (state_r)
      ST_T1: begin
        RD_O     = 1'b1;
        BUS_OE_O = 1'b1;
        BUS_O    = STK_DAT_I;
      end
      ST_T2: begin
        RD_O     = 1'b1;
        HA_O     = 1'b1;
        BUS_OE_O = 1'b1;
        BUS_O    = {cyc_r, STK_DAT_I[5:0]};
      end
      ST_T3: begin
        if (cyc_r == 2'b11) begin
          BUS_OE_O = 1'b1;
          BUS_O    = wdat_r;
        end else begin
          BUS_OE_O = 1'b0;
          BUS_O    = 8'h00;
        end
      end
      ST_T4: begin
        if (phase_r) begin
          PUSH_O = push_r;
          POP_O  = pop_r && !push_r;
        end else begin
          INCR_O = incr_r;
        end
      end
      default: begin
        BUS_O = 8'h00;
      end
    endcase
  end

  assign RD_DAT_O = rd_dat_r;
  assign STATE_O  = state_r;
  assign SYNC_O   = phase_r;
  assign BUSY_O   = (state_r != ST_IDLE);
  assign DONE_O   = (state_r == ST_T4) && phase_r;

endmodule
